// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative RV32M multiply/divide
// unit.
//   muldiv_op_e    - funct3 encodings of the M-extension instructions
//   muldiv_state_e - sequencer states (IDLE / CALC / DONE)
//   abs_val()      - magnitude of an operand given its effective sign
//   is_div_op()    - true for DIV/DIVU/REM/REMU
package muldiv_pkg;

    localparam int unsigned MULDIV_DW = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // Two's-complement magnitude. The most negative value maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [MULDIV_DW-1:0] abs_val(input logic [MULDIV_DW-1:0] value,
                                                      input logic                 is_neg);
        return is_neg ? (~value + 1'b1) : value;
    endfunction

    // All divide/remainder encodings have funct3[2] set.
    function automatic logic is_div_op(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// A shift-add multiply or restoring divide runs on operand magnitudes over
// DATA_WIDTH cycles, sharing one 2W accumulator; the sign is fixed up when the
// result is written. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_in, funct3_in M instruction present in execute and its funct3
//   op1_in, op2_in      rs1 / rs2 operands
//   flush_in            abort the current operation (no result produced)
//   busy_out            unit not idle
//   stall_out           hold the upstream pipeline
//   valid_out           result_out valid (one cycle)
//   result_out          instruction result (registered)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MULDIV_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_in,
    input  logic [2:0]            funct3_in,
    input  logic [DATA_WIDTH-1:0] op1_in,
    input  logic [DATA_WIDTH-1:0] op2_in,
    input  logic                  flush_in,
    output logic                  busy_out,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] result_out
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    muldiv_state_e   state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    muldiv_op_e      op_q, op_d;
    logic            neg_q, neg_d;       // sign to apply to the selected result
    logic [W-1:0]    opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*W-1:0]  acc_q, acc_d;       // {hi, lo}: product or {remainder, quotient}
    logic [W-1:0]    result_q, result_d;

    // Start-time decode of the incoming instruction
    muldiv_op_e      op_in;
    logic            s1_signed, s2_signed, s1, s2, rem_in;
    logic [W-1:0]    mag1, mag2;
    logic            div_zero, div_ovf;

    always_comb begin
        op_in     = muldiv_op_e'(funct3_in);
        s1_signed = !(op_in inside {OP_MULHU, OP_DIVU, OP_REMU});
        s2_signed = s1_signed && (op_in != OP_MULHSU);
        s1        = s1_signed && op1_in[W-1];
        s2        = s2_signed && op2_in[W-1];
        mag1      = abs_val(op1_in, s1);
        mag2      = abs_val(op2_in, s2);
        rem_in    = (op_in == OP_REM) || (op_in == OP_REMU);
        div_zero  = is_div_op(op_in) && (op2_in == '0);
        div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (op1_in == {1'b1, {(W-1){1'b0}}}) && (op2_in == '1);
    end

    // One iteration of each algorithm on the shared accumulator
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift, div_diff;
    logic           div_ok;
    logic [2*W-1:0] div_next, acc_step, prod;
    logic [W-1:0]   quo, rem, fin_result;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then
        // shift right, keeping the carry in the top bit.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};
        // Divide: shift the next dividend bit into the partial remainder and
        // subtract when it fits. The extra bit catches a remainder >= 2^W.
        div_shift = acc_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ok    = ~div_diff[W];
        div_next  = {(div_ok ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ok};
        acc_step  = is_div_op(op_q) ? div_next : mul_next;

        prod = neg_q ? (~acc_step + 1'b1) : acc_step;
        quo  = acc_step[W-1:0];
        rem  = acc_step[2*W-1:W];
        case (op_q)
            OP_MUL:                      fin_result = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_result = prod[2*W-1:W];
            OP_DIV, OP_DIVU:             fin_result = neg_q ? (~quo + 1'b1) : quo;
            default:                     fin_result = neg_q ? (~rem + 1'b1) : rem;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;

        if (flush_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        op_d    = op_in;
                        count_d = '0;
                        // Remainder takes the dividend's sign; everything else
                        // takes the product/quotient sign.
                        neg_d   = rem_in ? s1 : (s1 ^ s2);
                        if (div_zero) begin
                            result_d = rem_in ? op1_in : '1;
                            state_d  = ST_DONE;
                        end else if (div_ovf) begin
                            result_d = rem_in ? '0 : op1_in;
                            state_d  = ST_DONE;
                        end else begin
                            opnd_d  = is_div_op(op_in) ? mag2 : mag1;
                            acc_d   = {{W{1'b0}}, (is_div_op(op_in) ? mag1 : mag2)};
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d   = acc_step;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_COUNT) begin
                        result_d = fin_result;
                        state_d  = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign busy_out   = (state_q != ST_IDLE);
    assign stall_out  = ((state_q == ST_IDLE) && start_in && !flush_in) || (state_q == ST_CALC);
    assign valid_out  = (state_q == ST_DONE);
    assign result_out = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [2:0]  funct3_in = 3'b000;
    logic [31:0] op1_in = '0;
    logic [31:0] op2_in = '0;
    logic        flush_in = 1'b0;
    logic        busy_out, stall_out, valid_out;
    logic [31:0] result_out;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_in   (start_in),
        .funct3_in  (funct3_in),
        .op1_in     (op1_in),
        .op2_in     (op2_in),
        .flush_in   (flush_in),
        .busy_out   (busy_out),
        .stall_out  (stall_out),
        .valid_out  (valid_out),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        int          start_cyc;
        int          lat;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model: RISC-V M semantics from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        logic is_div, signed_div, ovf;
        is_div     = (f3 >= 3'd4);
        signed_div = (f3 == 3'd4) || (f3 == 3'd6);
        ovf        = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (is_div && ((b == 0) || (signed_div && ovf))) return 1;
        return 33;
    endfunction

    // Monitor: every valid_out must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: cycle %0d result=%08h, no operation outstanding",
                         cyc, result_out);
            end else begin
                mon_e = sb_q.pop_front();
                if (result_out !== mon_e.res || (cyc - mon_e.start_cyc) != mon_e.lat) begin
                    n_errors++;
                    $display("FAIL result f3=%0d a=%08h b=%08h: got %08h latency %0d, want %08h latency %0d",
                             mon_e.f3, mon_e.a, mon_e.b, result_out, cyc - mon_e.start_cyc,
                             mon_e.res, mon_e.lat);
                end else begin
                    $display("ok   f3=%0d a=%08h b=%08h -> %08h latency %0d",
                             mon_e.f3, mon_e.a, mon_e.b, result_out, mon_e.lat);
                end
            end
        end
    end

    // Issue one instruction and follow its handshake until the unit is idle.
    // Called just after a rising edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat, k, guard;
        bit   bad;
        lat = ref_latency(f3, a, b);
        e.res = ref_model(f3, a, b);
        e.start_cyc = cyc;
        e.lat = lat;
        e.f3 = f3;
        e.a = a;
        e.b = b;
        sb_q.push_back(e);
        start_in  = 1'b1;
        funct3_in = f3;
        op1_in    = a;
        op2_in    = b;
        #1;
        bad = (stall_out !== 1'b1) || (busy_out !== 1'b0);
        @(posedge clk); #1;
        start_in = 1'b0;
        guard = 0;
        while (busy_out === 1'b1 && guard < 100) begin
            k = cyc - e.start_cyc;
            if (stall_out !== (k < lat)) bad = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        k = cyc - e.start_cyc;
        n_checks++;
        if (bad || guard >= 100 || k != lat + 1 || stall_out !== 1'b0) begin
            n_errors++;
            $display("FAIL handshake f3=%0d a=%08h b=%08h: idle at offset %0d stall/busy ok=%0d, want idle at offset %0d",
                     f3, a, b, k, !bad, lat + 1);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [6];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'hFFFF_FFFF;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        #3;
        n_checks++;
        if (busy_out !== 1'b0 || stall_out !== 1'b0 || valid_out !== 1'b0 || result_out !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b stall=%b valid=%b result=%08h, want 0 0 0 00000000",
                     busy_out, stall_out, valid_out, result_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(3'd0, 32'd7,         32'hFFFF_FFFD);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100,       32'd7);
        issue(3'd7, 32'd100,       32'd7);
        issue(3'd5, 32'd5,         32'd0);
        issue(3'd6, 32'd5,         32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Flush in cycle 10 of a divide; restart in cycle 12.
        s = cyc;
        start_in = 1'b1; funct3_in = 3'd4; op1_in = 32'd1000; op2_in = 32'd3;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        n_checks++;
        if (busy_out !== 1'b0 || valid_out !== 1'b0 || (cyc - s) != 11) begin
            n_errors++;
            $display("FAIL flush_idle: offset %0d busy=%b valid=%b, want offset 11 busy=0 valid=0",
                     cyc - s, busy_out, valid_out);
        end
        @(posedge clk); #1;
        issue(3'd5, 32'd1000, 32'd3);

        // Asynchronous reset in cycle 5 of a multiply.
        s = cyc;
        start_in = 1'b1; funct3_in = 3'd0; op1_in = 32'd12345; op2_in = 32'd678;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_out !== 1'b0 || stall_out !== 1'b0 || valid_out !== 1'b0 || result_out !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mid_calc: busy=%b stall=%b valid=%b result=%08h, want 0 0 0 00000000",
                     busy_out, stall_out, valid_out, result_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // Randomised operations against the reference model
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_results: %0d outstanding, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
